// File: rtl/pool2_exec.sv
// 2x2/stride-2 signed max pooling over sixteen f4 feature-map buffers.
// Reads each window as four back-to-back RAM reads and writes one s4 result per window.
//
// state | meaning
// IDLE  | waiting for start; no reads or writes
// READ  | issuing one shared f4 read per cycle, 4 per window
// DRAIN | reads finished; last returned data still being pooled/written
module pool2_exec #(
  parameter int DW   = 16,
  parameter int FMAP = 8,
  localparam int OS  = FMAP / 2,
  localparam int AW  = $clog2(FMAP * FMAP),
  localparam int OW  = (OS > 1) ? $clog2(OS * OS) : 1,
  localparam int CW  = (OS > 1) ? $clog2(OS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] f4_raddr,
  output logic          f4_rden,
  input  logic [DW-1:0] f4_1_rdata,
  input  logic [DW-1:0] f4_2_rdata,
  input  logic [DW-1:0] f4_3_rdata,
  input  logic [DW-1:0] f4_4_rdata,
  input  logic [DW-1:0] f4_5_rdata,
  input  logic [DW-1:0] f4_6_rdata,
  input  logic [DW-1:0] f4_7_rdata,
  input  logic [DW-1:0] f4_8_rdata,
  input  logic [DW-1:0] f4_9_rdata,
  input  logic [DW-1:0] f4_10_rdata,
  input  logic [DW-1:0] f4_11_rdata,
  input  logic [DW-1:0] f4_12_rdata,
  input  logic [DW-1:0] f4_13_rdata,
  input  logic [DW-1:0] f4_14_rdata,
  input  logic [DW-1:0] f4_15_rdata,
  input  logic [DW-1:0] f4_16_rdata,
  output logic [OW-1:0] s4_waddr,
  output logic          s4_wen,
  output logic [DW-1:0] s4_1_wdata,
  output logic [DW-1:0] s4_2_wdata,
  output logic [DW-1:0] s4_3_wdata,
  output logic [DW-1:0] s4_4_wdata,
  output logic [DW-1:0] s4_5_wdata,
  output logic [DW-1:0] s4_6_wdata,
  output logic [DW-1:0] s4_7_wdata,
  output logic [DW-1:0] s4_8_wdata,
  output logic [DW-1:0] s4_9_wdata,
  output logic [DW-1:0] s4_10_wdata,
  output logic [DW-1:0] s4_11_wdata,
  output logic [DW-1:0] s4_12_wdata,
  output logic [DW-1:0] s4_13_wdata,
  output logic [DW-1:0] s4_14_wdata,
  output logic [DW-1:0] s4_15_wdata,
  output logic [DW-1:0] s4_16_wdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [CW-1:0] C_MAX = CW'(OS - 1);

  logic [1:0]    state;
  logic [1:0]    phase;
  logic [CW-1:0] ox, oy;
  logic [1:0]    nxt_phase;
  logic [CW-1:0] nxt_ox, nxt_oy;
  logic [AW-1:0] nxt_addr;
  logic          last_rd;

  logic          rd_vld;
  logic [1:0]    rd_phase;
  logic [OW-1:0] rd_win;
  logic          rd_last;

  logic [DW-1:0] rdata   [16];
  logic [DW-1:0] run_max [16];
  logic [DW-1:0] pick    [16];
  logic [DW-1:0] wdata   [16];

  assign rdata[0]  = f4_1_rdata;
  assign rdata[1]  = f4_2_rdata;
  assign rdata[2]  = f4_3_rdata;
  assign rdata[3]  = f4_4_rdata;
  assign rdata[4]  = f4_5_rdata;
  assign rdata[5]  = f4_6_rdata;
  assign rdata[6]  = f4_7_rdata;
  assign rdata[7]  = f4_8_rdata;
  assign rdata[8]  = f4_9_rdata;
  assign rdata[9]  = f4_10_rdata;
  assign rdata[10] = f4_11_rdata;
  assign rdata[11] = f4_12_rdata;
  assign rdata[12] = f4_13_rdata;
  assign rdata[13] = f4_14_rdata;
  assign rdata[14] = f4_15_rdata;
  assign rdata[15] = f4_16_rdata;

  assign s4_1_wdata  = wdata[0];
  assign s4_2_wdata  = wdata[1];
  assign s4_3_wdata  = wdata[2];
  assign s4_4_wdata  = wdata[3];
  assign s4_5_wdata  = wdata[4];
  assign s4_6_wdata  = wdata[5];
  assign s4_7_wdata  = wdata[6];
  assign s4_8_wdata  = wdata[7];
  assign s4_9_wdata  = wdata[8];
  assign s4_10_wdata = wdata[9];
  assign s4_11_wdata = wdata[10];
  assign s4_12_wdata = wdata[11];
  assign s4_13_wdata = wdata[12];
  assign s4_14_wdata = wdata[13];
  assign s4_15_wdata = wdata[14];
  assign s4_16_wdata = wdata[15];

  assign busy    = (state != S_IDLE);
  assign last_rd = (phase == 2'd3) && (ox == C_MAX) && (oy == C_MAX);

  // Next read position: phase walks the 2x2 window, then ox, then oy.
  always_comb begin
    nxt_phase = phase + 2'd1;
    nxt_ox    = ox;
    nxt_oy    = oy;
    if (phase == 2'd3) begin
      if (ox == C_MAX) begin
        nxt_ox = '0;
        nxt_oy = oy + CW'(1);
      end else begin
        nxt_ox = ox + CW'(1);
      end
    end
    nxt_addr = AW'((2 * int'(nxt_oy) + int'(nxt_phase[1])) * FMAP
                   + 2 * int'(nxt_ox) + int'(nxt_phase[0]));
  end

  // Phase 0 loads unconditionally; later phases replace only on strictly greater.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      if ((rd_phase == 2'd0) || ($signed(rdata[k]) > $signed(run_max[k])))
        pick[k] = rdata[k];
      else
        pick[k] = run_max[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      phase    <= '0;
      ox       <= '0;
      oy       <= '0;
      f4_rden  <= 1'b0;
      f4_raddr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state    <= S_READ;
            phase    <= '0;
            ox       <= '0;
            oy       <= '0;
            f4_rden  <= 1'b1;
            f4_raddr <= '0;
          end
        end
        S_READ: begin
          if (last_rd) begin
            state   <= S_DRAIN;
            f4_rden <= 1'b0;
          end else begin
            phase    <= nxt_phase;
            ox       <= nxt_ox;
            oy       <= nxt_oy;
            f4_raddr <= nxt_addr;
          end
        end
        S_DRAIN: begin
          if (done) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Return pipeline: tags follow the read by one cycle to line up with RAM data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld   <= 1'b0;
      rd_phase <= '0;
      rd_win   <= '0;
      rd_last  <= 1'b0;
      s4_wen   <= 1'b0;
      s4_waddr <= '0;
      done     <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        run_max[k] <= '0;
        wdata[k]   <= '0;
      end
    end else begin
      rd_vld   <= f4_rden;
      rd_phase <= phase;
      rd_win   <= OW'(int'(oy) * OS + int'(ox));
      rd_last  <= last_rd;
      s4_wen   <= rd_vld && (rd_phase == 2'd3);
      done     <= rd_vld && (rd_phase == 2'd3) && rd_last;
      if (rd_vld) begin
        if (rd_phase == 2'd3) begin
          s4_waddr <= rd_win;
          for (int k = 0; k < 16; k++) wdata[k] <= pick[k];
        end else begin
          for (int k = 0; k < 16; k++) run_max[k] <= pick[k];
        end
      end
    end
  end

endmodule

// File: tb/tb_pool2_exec.sv
// Self-checking bench for pool2_exec: RAM model, write scoreboard, per-cycle timing monitor.
module tb_pool2_exec;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic busy, done, f4_rden, s4_wen;
  logic [5:0] f4_raddr;
  logic [3:0] s4_waddr;
  logic [DW-1:0] rd [16];
  logic [DW-1:0] wd [16];

  always #5 clk = ~clk;

  pool2_exec #(.DW(DW), .FMAP(8)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .f4_raddr(f4_raddr), .f4_rden(f4_rden),
    .f4_1_rdata(rd[0]),   .f4_2_rdata(rd[1]),   .f4_3_rdata(rd[2]),   .f4_4_rdata(rd[3]),
    .f4_5_rdata(rd[4]),   .f4_6_rdata(rd[5]),   .f4_7_rdata(rd[6]),   .f4_8_rdata(rd[7]),
    .f4_9_rdata(rd[8]),   .f4_10_rdata(rd[9]),  .f4_11_rdata(rd[10]), .f4_12_rdata(rd[11]),
    .f4_13_rdata(rd[12]), .f4_14_rdata(rd[13]), .f4_15_rdata(rd[14]), .f4_16_rdata(rd[15]),
    .s4_waddr(s4_waddr), .s4_wen(s4_wen),
    .s4_1_wdata(wd[0]),   .s4_2_wdata(wd[1]),   .s4_3_wdata(wd[2]),   .s4_4_wdata(wd[3]),
    .s4_5_wdata(wd[4]),   .s4_6_wdata(wd[5]),   .s4_7_wdata(wd[6]),   .s4_8_wdata(wd[7]),
    .s4_9_wdata(wd[8]),   .s4_10_wdata(wd[9]),  .s4_11_wdata(wd[10]), .s4_12_wdata(wd[11]),
    .s4_13_wdata(wd[12]), .s4_14_wdata(wd[13]), .s4_15_wdata(wd[14]), .s4_16_wdata(wd[15])
  );

  logic [DW-1:0] mem [16][64];

  always @(posedge clk)
    if (f4_rden)
      for (int k = 0; k < 16; k++) rd[k] <= mem[k][f4_raddr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int t0 = -1000;
  bit chk_timing = 1'b0;
  bit sb_en = 1'b1;
  int wcount = 0;
  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [15:0] a0, a1, a2, a3, ex;
  } vec_t;
  vec_t vecs [8];

  typedef struct {
    int cyc;
    int waddr;
    logic [15:0][15:0] d;
  } exp_t;
  exp_t sb [$];

  logic [DW-1:0] cap [16][16];

  function automatic int rd_addr(int w, int p);
    int oy = w / 4;
    int ox = w % 4;
    return (2 * oy + p / 2) * 8 + 2 * ox + p % 2;
  endfunction

  function automatic logic [15:0] win_max(int k, int w);
    logic signed [15:0] m;
    m = mem[k][rd_addr(w, 0)];
    for (int p = 1; p < 4; p++)
      if ($signed(mem[k][rd_addr(w, p)]) > m) m = mem[k][rd_addr(w, p)];
    return m;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] ex);
    n_vec++;
    if (act !== ex) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, ex);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(bit push);
    exp_t e;
    start = 1'b1;
    t0 = cyc;
    if (push) begin
      for (int w = 0; w < 16; w++) begin
        e.cyc = t0 + 4 * w + 6;
        e.waddr = w;
        for (int k = 0; k < 16; k++) e.d[k] = win_max(k, w);
        sb.push_back(e);
      end
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_rel(int n);
    while (cyc - t0 < n) tick();
  endtask

  task automatic drain();
    int b = 0;
    while (sb.size() > 0 && b < 200) begin
      tick();
      b++;
    end
    chk("sb_drain", sb.size(), 0);
    repeat (3) tick();
  endtask

  task automatic load_ramp();
    for (int k = 0; k < 16; k++)
      for (int a = 0; a < 64; a++) mem[k][a] = 16'(a + 64 * k);
  endtask

  task automatic chk_all_reset();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rden", f4_rden, 0);
    chk("rst_wen", s4_wen, 0);
    chk("rst_raddr", f4_raddr, 0);
    chk("rst_waddr", s4_waddr, 0);
    for (int k = 0; k < 16; k++) chk("rst_wdata", wd[k], 0);
  endtask

  // Timing monitor and write scoreboard, sampled mid-cycle.
  always @(negedge clk) begin
    int rel;
    exp_t e;
    rel = cyc - t0;
    if (chk_timing) begin
      chk("rden", f4_rden, (rel >= 1 && rel <= 64));
      if (rel >= 1 && rel <= 64)
        chk("raddr", f4_raddr, rd_addr((rel - 1) / 4, (rel - 1) % 4));
      chk("busy", busy, (rel >= 1 && rel <= 66));
      chk("done", done, (rel == 66));
      chk("wen", s4_wen, (rel >= 6 && rel <= 66 && (rel - 6) % 4 == 0));
    end
    if (sb_en && s4_wen) begin
      wcount++;
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write @cyc %0d: got waddr %0d expected no write", cyc, s4_waddr);
      end else begin
        e = sb.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("waddr", s4_waddr, e.waddr);
        for (int k = 0; k < 16; k++) chk("wdata", wd[k], e.d[k]);
      end
      for (int k = 0; k < 16; k++) cap[s4_waddr][k] = wd[k];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'h8000, 16'hFFFF, 16'h8001, 16'hFFFE, 16'hFFFF};
    vecs[1] = '{16'h7FFF, 16'h0000, 16'h8000, 16'h0001, 16'h7FFF};
    vecs[2] = '{16'h0005, 16'hFFFB, 16'h0003, 16'h0001, 16'h0005};
    vecs[3] = '{16'hFFF0, 16'h0010, 16'hFFF1, 16'h000F, 16'h0010};
    vecs[4] = '{16'h8000, 16'h8000, 16'h0000, 16'h8000, 16'h0000};
    vecs[5] = '{16'h1234, 16'h1233, 16'h1200, 16'h1235, 16'h1235};
    vecs[6] = '{16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE};
    vecs[7] = '{16'h0001, 16'h7FFE, 16'h7FFF, 16'h7FFE, 16'h7FFF};

    rst = 1'b1;
    repeat (3) tick();
    chk_all_reset();
    rst = 1'b0;
    chk_timing = 1'b1;
    tick();

    // Ramp frame with full cycle checking
    load_ramp();
    wcount = 0;
    run_frame(1'b1);
    drain();
    chk("writes_ramp", wcount, 16);
    chk("ramp_s4_1_w0", cap[0][0], 9);
    chk("ramp_s4_1_w5", cap[5][0], 27);
    chk("ramp_s4_1_w15", cap[15][0], 63);
    chk("ramp_s4_16_w0", cap[0][15], 969);

    // Signed-compare table on channel 1, random data elsewhere
    for (int k = 0; k < 16; k++)
      for (int a = 0; a < 64; a++) mem[k][a] = 16'($urandom);
    for (int i = 0; i < 8; i++) begin
      mem[0][rd_addr(i, 0)] = vecs[i].a0;
      mem[0][rd_addr(i, 1)] = vecs[i].a1;
      mem[0][rd_addr(i, 2)] = vecs[i].a2;
      mem[0][rd_addr(i, 3)] = vecs[i].a3;
    end
    run_frame(1'b1);
    drain();
    for (int i = 0; i < 8; i++) chk("vec_max", cap[i][0], vecs[i].ex);

    // Busy protection: starts at 20 and 66 ignored, start at 67 opens a new frame
    load_ramp();
    wcount = 0;
    run_frame(1'b1);
    wait_rel(20);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_rel(66);
    start = 1'b1;
    tick();
    run_frame(1'b1);
    drain();
    chk("writes_b2b", wcount, 32);
    chk("b2b_s4_1_w15", cap[15][0], 63);

    // Reset mid-frame
    chk_timing = 1'b0;
    sb_en = 1'b0;
    run_frame(1'b0);
    wait_rel(30);
    rst = 1'b1;
    tick();
    chk_all_reset();
    rst = 1'b0;
    repeat (8) begin
      tick();
      chk("post_rst_rden", f4_rden, 0);
      chk("post_rst_wen", s4_wen, 0);
      chk("post_rst_busy", busy, 0);
    end
    t0 = -1000;
    sb_en = 1'b1;
    chk_timing = 1'b1;
    wcount = 0;
    run_frame(1'b1);
    drain();
    chk("writes_after_rst", wcount, 16);

    // Reset held together with start
    rst = 1'b1;
    start = 1'b1;
    repeat (4) begin
      tick();
      chk("rststart_busy", busy, 0);
      chk("rststart_rden", f4_rden, 0);
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (4) begin
      tick();
      chk("idle_rden", f4_rden, 0);
      chk("idle_busy", busy, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
